// File: rtl/paint_pkg.sv
// -----------------------------------------------------------------------------
// paint_pkg
//   Shared definitions for the push-button front end of the paint datapath.
//   - key_state_e : per-key FSM state encoding
//   - KEY_*       : bit positions of the four direction keys in key_n/step/held
//   - max3        : helper used to size the per-key counters
// -----------------------------------------------------------------------------
package paint_pkg;

  // Per-key state machine states.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HOLD_WAIT  = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } key_state_e;

  // Bit positions shared by key_n, step and held.
  localparam int KEY_RIGHT = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_LEFT  = 3;

  // Largest of three integers; the counters are sized from the largest
  // timing parameter so a single width covers every state.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_chan.sv
// -----------------------------------------------------------------------------
// key_chan
//   One push-button channel: 2-flop synchronizer, debounce / auto-repeat FSM
//   and a saturating cycle counter.
//
//   Configuration: define KEY_STEP_AUTOREPEAT_EN to enable auto-repeat
//   (HOLD_WAIT times out into REPEAT). Without it a debounced press yields
//   exactly one step and REPEAT is never entered.
//
//   Ports
//     clk    : system clock
//     resetn : asynchronous active-low reset
//     key_n  : raw button level, active-low (asynchronous to clk)
//     step   : one-cycle move pulse (registered)
//     held   : debounced pressed level, active-high (registered)
// -----------------------------------------------------------------------------
module key_chan
  import paint_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic step,
  output logic held
);

  // One extra bit above what the largest parameter needs, so the counter
  // never has to wrap while it is still below any threshold.
  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  // The counter runs 0..N-1 across N stable cycles, so the exit test is
  // against N-1. A parameter of 0 behaves like 1.
  localparam int DB_LAST_I = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_LAST_I);

`ifdef KEY_STEP_AUTOREPEAT_EN
  // Delay/period below 2 would let step fire on back-to-back cycles;
  // clamp so a pulse is always followed by at least one idle cycle.
  localparam int DELAY_EFF  = (REPEAT_DELAY  > 2) ? REPEAT_DELAY  : 2;
  localparam int PERIOD_EFF = (REPEAT_PERIOD > 2) ? REPEAT_PERIOD : 2;
  localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY_EFF - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_EFF - 1);
`endif

  logic       sync1;
  logic       sync2;
  logic       pressed;
  key_state_e state;
  logic [CW-1:0] cnt;

  // Synchronized key level, active-high.
  assign pressed = ~sync2;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Synchronizer, FSM, counter and registered outputs in one process.
  // Every state change clears cnt; inside a state cnt counts stable cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      step  <= 1'b0;
      held  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      step  <= 1'b0;

      case (state)
        IDLE: begin
          if (pressed) begin
            state <= PRESS_DB;
            cnt   <= '0;
          end
        end

        PRESS_DB: begin
          if (!pressed) begin
            // Bounce: drop back without a step.
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= DB_LAST) begin
            state <= HOLD_WAIT;
            cnt   <= '0;
            held  <= 1'b1;
            step  <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        HOLD_WAIT: begin
          if (!pressed) begin
            state <= RELEASE_DB;
            cnt   <= '0;
`ifdef KEY_STEP_AUTOREPEAT_EN
          end else if (cnt >= DELAY_LAST) begin
            state <= REPEAT;
            cnt   <= '0;
            step  <= 1'b1;
`endif
          end else begin
            // Without auto-repeat this just saturates and waits for release.
            cnt <= sat_inc(cnt);
          end
        end

`ifdef KEY_STEP_AUTOREPEAT_EN
        REPEAT: begin
          if (!pressed) begin
            state <= RELEASE_DB;
            cnt   <= '0;
          end else if (cnt >= PERIOD_LAST) begin
            // Same state, but the period restarts from each pulse.
            cnt  <= '0;
            step <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
`endif

        RELEASE_DB: begin
          if (pressed) begin
            // Release was a bounce: key is still held, no new step.
            state <= HOLD_WAIT;
            cnt   <= '0;
          end else if (cnt >= DB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= 1'b0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_step_gen.sv
// -----------------------------------------------------------------------------
// key_step_gen
//   Turns the four raw direction push-buttons into debounced held levels and
//   one-cycle step pulses for the paint datapath. Each key runs in its own
//   key_chan; this level only adds the opposing-key rule: while both keys of
//   an opposing pair are held, neither of them steps (their FSMs keep going).
//
//   Configuration: define KEY_STEP_AUTOREPEAT_EN to enable auto-repeat while
//   a key is held (see key_chan).
//
//   Ports
//     clk    : system clock (CLOCK_50 domain)
//     resetn : asynchronous active-low reset
//     key_n  : raw push-buttons, active-low; 0=right 1=down 2=up 3=left
//     step   : one-cycle move pulses, same bit map
//     held   : debounced pressed level per key, active-high
// -----------------------------------------------------------------------------
module key_step_gen
  import paint_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] key_n,
  output logic [3:0] step,
  output logic [3:0] held
);

  logic [3:0] raw_step;
  logic       vert_block;
  logic       horz_block;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      key_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
        .clk    (clk),
        .resetn (resetn),
        .key_n  (key_n[gi]),
        .step   (raw_step[gi]),
        .held   (held[gi])
      );
    end
  endgenerate

  // Masking uses the same-cycle held values, so the step of the key that
  // completes an opposing pair is suppressed as well.
  assign vert_block = held[KEY_UP]   & held[KEY_DOWN];
  assign horz_block = held[KEY_LEFT] & held[KEY_RIGHT];

  always_comb begin
    step = raw_step;
    if (vert_block) begin
      step[KEY_UP]   = 1'b0;
      step[KEY_DOWN] = 1'b0;
    end
    if (horz_block) begin
      step[KEY_LEFT]  = 1'b0;
      step[KEY_RIGHT] = 1'b0;
    end
  end

endmodule
